// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: merges instruction and data buses onto one shared memory port with a watchdog
// Build option: ARB_ROUND_ROBIN_EN selects round-robin contention (default is fixed data priority).
// Ports:
//   i_clk, i_rst_n                          clock, asynchronous active-low reset
//   i_instr_req/addr, o_instr_rdata/ack     instruction read requester
//   i_data_req/we/addr/wdata, o_data_rdata/ack  data load/store requester
//   o_mem_req/we/addr/wdata, i_mem_rdata/ready  shared memory port (outputs registered)
//   o_timeout                               sticky watchdog-abort flag
module mem_bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_instr_req,
  input  logic [ADDR_WIDTH-1:0] i_instr_addr,
  output logic [DATA_WIDTH-1:0] o_instr_rdata,
  output logic                  o_instr_ack,
  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [ADDR_WIDTH-1:0] i_data_addr,
  input  logic [DATA_WIDTH-1:0] i_data_wdata,
  output logic [DATA_WIDTH-1:0] o_data_rdata,
  output logic                  o_data_ack,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ready,
  output logic                  o_timeout
);
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;
  state_t state;
  logic [15:0] cnt, cnt_inc;
  logic last_d, grant_d, is_d, expired;
  logic [DATA_WIDTH-1:0] rd;
  // last_d: 1 when the data side won the most recent grant; only steers contention in round-robin builds
  always_comb begin
    cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    expired = cnt_inc >= TO;
    grant_d = i_data_req && (!i_instr_req || !RR || !last_d);
    is_d = state == BUSY_D;
    rd = i_mem_ready ? i_mem_rdata : '1;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last_d <= 1'b0;
      o_instr_rdata <= '0;
      o_instr_ack <= 1'b0;
      o_data_rdata <= '0;
      o_data_ack <= 1'b0;
      o_mem_req <= 1'b0;
      o_mem_we <= 1'b0;
      o_mem_addr <= '0;
      o_mem_wdata <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_instr_ack <= 1'b0;
      o_data_ack <= 1'b0;
      case (state)
        IDLE: if (i_instr_req || i_data_req) begin
          state <= grant_d ? BUSY_D : BUSY_I;
          last_d <= grant_d;
          cnt <= '0;
          o_mem_req <= 1'b1;
          o_mem_we <= grant_d && i_data_we;
          o_mem_addr <= grant_d ? i_data_addr : i_instr_addr;
          o_mem_wdata <= grant_d ? i_data_wdata : '0;
        end
        BUSY_I, BUSY_D: begin
          if (!i_mem_ready) cnt <= cnt_inc;
          // ready on the expiry edge counts as a normal completion
          if (i_mem_ready || expired) begin
            state <= is_d ? RESP_D : RESP_I;
            o_mem_req <= 1'b0;
            o_instr_ack <= !is_d;
            o_data_ack <= is_d;
            if (!i_mem_ready) o_timeout <= 1'b1;
            if (!is_d) o_instr_rdata <= rd;
            else if (!o_mem_we) o_data_rdata <= rd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
